// File: rtl/icache_pkg.sv
// icache_pkg: shared defaults, address-split helpers and FSM state encoding for the icache.
package icache_pkg;
  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESP} state_e;
  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction
  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_bits(input int addr_width, input int lines, input int words_per_line);
    return addr_width - index_bits(lines) - offset_bits(words_per_line) - 2;
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays in flops.
// Ports: rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o (combinational read);
//        wr_en_i/wr_idx_i/wr_tag_i/wr_data_i/wr_valid_i (one-line write); clear_i drops every valid bit.
module icache_line_store import icache_pkg::*; #(
  parameter int LINES = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int IB = index_bits(LINES),
  localparam int TB = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE),
  localparam int LW = 32 * WORDS_PER_LINE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IB-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [TB-1:0] rd_tag_o,
  output logic [LW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [IB-1:0] wr_idx_i,
  input  logic [TB-1:0] wr_tag_i,
  input  logic [LW-1:0] wr_data_i,
  input  logic          wr_valid_i,
  input  logic          clear_i
);
  logic [LINES-1:0] valid_q;
  logic [TB-1:0] tag_q [LINES];
  logic [LW-1:0] data_q [LINES];
  // Clear wins over a simultaneous install so a fence during the refill edge leaves nothing valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (clear_i) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
  end
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only instruction cache with single-beat line refill.
// Ports: core side icache_addr/icache_re in, icache_req_ready/icache_resp_valid/icache_dout out;
//        invalidate clears all lines; memory side mem_req_valid/mem_req_ready/mem_req_addr request,
//        mem_resp_valid/mem_resp_data full-line response.
module icache_responder import icache_pkg::*; #(
  parameter int LINES = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       icache_addr,
  input  logic                        icache_re,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [31:0]                 icache_dout,
  input  logic                        invalidate,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  input  logic                        mem_resp_valid,
  input  logic [32*WORDS_PER_LINE-1:0] mem_resp_data
);
  localparam int OB = offset_bits(WORDS_PER_LINE);
  localparam int IB = index_bits(LINES);
  localparam int TB = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE);
  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic inv_seen_q, inv_seen_d;
  logic [ADDR_WIDTH-3:0] req_q, req_d;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [OB-1:0] woff;
  logic rd_valid;
  logic [TB-1:0] rd_tag;
  logic [WORDS_PER_LINE-1:0][31:0] rd_words;
  logic hit, miss, in_idle, in_miss, refill, unused_addr;
  // The request latch drops the byte-offset bits; they never affect the result.
  assign unused_addr = ^icache_addr[1:0];
  assign woff = req_q[OB-1:0];
  assign idx = req_q[OB+IB-1:OB];
  assign tag = req_q[ADDR_WIDTH-3:OB+IB];
  assign in_idle = state_q == IDLE;
  assign in_miss = state_q == MISS_REQ || state_q == MISS_WAIT;
  assign hit = pending_q && rd_valid && rd_tag == tag && !invalidate;
  assign miss = in_idle && pending_q && !hit;
  assign refill = state_q == MISS_WAIT && mem_resp_valid;
  assign icache_req_ready = !reset && (state_q == RESP || (in_idle && !miss));
  assign icache_resp_valid = state_q == RESP || (in_idle && hit);
  assign icache_dout = icache_resp_valid ? rd_words[woff] : '0;
  assign mem_req_valid = state_q == MISS_REQ;
  assign mem_req_addr = {req_q[ADDR_WIDTH-3:OB], {(OB+2){1'b0}}};
  icache_line_store #(
    .LINES(LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_store (
    .clk(clk),
    .rst(reset),
    .rd_idx_i(idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o(rd_tag),
    .rd_data_o(rd_words),
    .wr_en_i(refill),
    .wr_idx_i(idx),
    .wr_tag_i(tag),
    .wr_data_i(mem_resp_data),
    .wr_valid_i(!(inv_seen_q || invalidate)),
    .clear_i(invalidate)
  );
  always_comb begin
    pending_d = icache_req_ready ? icache_re : pending_q;
    req_d = icache_req_ready && icache_re ? icache_addr[ADDR_WIDTH-1:2] : req_q;
    // A fence seen anywhere in the refill keeps the installed line from being marked valid.
    inv_seen_d = in_miss && (inv_seen_q || invalidate);
    state_d = in_idle ? (miss ? MISS_REQ : IDLE) :
              state_q == MISS_REQ ? (mem_req_ready ? MISS_WAIT : MISS_REQ) :
              state_q == MISS_WAIT ? (mem_resp_valid ? RESP : MISS_WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      inv_seen_q <= 1'b0;
      req_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      inv_seen_q <= inv_seen_d;
      req_q <= req_d;
    end
  end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
Direct-mapped, read-only instruction cache. It is the responder end of the core's icache port (icache_addr/icache_re out of the core; icache_dout/icache_req_ready/icache_resp_valid back to it). Hits return the addressed word one cycle after acceptance. Misses fetch a whole line from the backing memory through a valid/ready request and a valid-qualified response, install the line, then deliver the word.

Parameters:
LINES, 64, number of cache lines (power of 2, >=2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)
ADDR_WIDTH, 32, byte-address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
icache_addr  input  ADDR_WIDTH  byte address from core; bits [1:0] ignored
icache_re  input  1  read request from core
icache_req_ready  output  1  cache can accept a request this cycle
icache_resp_valid  output  1  icache_dout holds the response to the last accepted request
icache_dout  output  32  instruction word
invalidate  input  1  one-cycle pulse; clears all valid bits (fence.i)
mem_req_valid  output  1  line refill request
mem_req_ready  input  1  memory accepts the request
mem_req_addr  output  ADDR_WIDTH  line-aligned refill address (offset bits zero)
mem_resp_valid  input  1  refill data valid, one beat carries the full line
mem_resp_data  input  32*WORDS_PER_LINE  line data, word 0 in the LSBs

Behaviour:
- Reset (async): state=IDLE; all valid bits 0; pending=0. Outputs: icache_req_ready=0 while reset is high, 1 in the first cycle after release; icache_resp_valid=0; mem_req_valid=0; icache_dout=0.
- Address split: [1:0] byte, next log2(WORDS_PER_LINE) bits word offset, next log2(LINES) bits index, remainder tag.
- Accept: request is accepted when icache_re && icache_req_ready. The address is latched into req_addr and pending is set. With icache_re=0, pending clears and no response is produced.
- IDLE, pending, lookup on req_addr:
  - hit = valid[idx] && tag match && !invalidate.
  - Hit: icache_resp_valid=1 and icache_dout=word in the same cycle (accept cycle N, response N+1). icache_req_ready stays 1, so back-to-back hits give one word per cycle.
  - Miss: icache_resp_valid=0, icache_req_ready=0; next state MISS_REQ.
- MISS_REQ: mem_req_valid=1, mem_req_addr=line-aligned req_addr, held stable until mem_req_ready. Transfer completes in the cycle both are high; next state MISS_WAIT.
- MISS_WAIT: mem_req_valid=0. When mem_resp_valid=1, write the line data and tag, set valid[idx]=1 (suppressed if an invalidate occurred during this miss); next state RESP.
- RESP: icache_resp_valid=1, icache_dout=requested word from the installed line. icache_req_ready=1, so a new request may be accepted; next state IDLE.
- icache_req_ready=0 in MISS_REQ and MISS_WAIT, and in IDLE during a miss cycle. icache_addr and icache_re are don't-care in those cycles.
- invalidate:
  - In IDLE it clears all valid bits at the next edge, and a lookup in the same cycle is a miss.
  - During MISS_REQ or MISS_WAIT it sets inv_seen. The refill still completes and the word is delivered, but the line is not marked valid. inv_seen clears on return to IDLE.
- mem_resp_valid outside MISS_WAIT is ignored. Exactly one refill is outstanding at most.
- Reset asserted mid-refill aborts immediately: state IDLE, mem_req_valid=0. A late mem_resp_valid after reset is ignored.
- Latency: hit = 1 cycle; miss = 1 (lookup) + 1 + request-wait + response-wait + 1 (RESP).

Decomposition:
- icache_pkg: OFFSET_BITS, INDEX_BITS, TAG_BITS derivations; state encoding IDLE/MISS_REQ/MISS_WAIT/RESP.
- Sub-module icache_line_store: valid/tag/data arrays in flops. Provides a combinational read port, a single-line write port, and a clear-all-valid input.
- Top holds the FSM, request latch, hit compare and word select.

Test Plan:
1. Cold read 0x0000_0040 with memory returning line {0x13,0x93,0x113,0x193}: mem_req_addr=0x40; after the response, resp_valid=1 with dout=0x13. An immediate reread of 0x44 hits, with dout=0x93 one cycle after accept.
2. Streaming 0x40,0x44,0x48,0x4C after warm-up: one response per cycle, req_ready never drops, mem_req_valid stays 0.
3. Conflict: read 0x40 then 0x1040 (LINES=64, 16B lines, same index): second access misses and refills. A following read of 0x40 misses again.
4. mem_req_ready held low 5 cycles: mem_req_valid and mem_req_addr held stable, req_ready=0 throughout. The response arrives only after the handshake.
5. invalidate pulsed in MISS_WAIT on 0x80: word still returned, but the next read of 0x80 misses. invalidate in IDLE makes a previously hitting 0x40 miss.
6. reset asserted during MISS_WAIT: outputs reach reset values asynchronously. A stale mem_resp_valid afterwards causes no resp_valid, and 0x40 misses afterwards.
